jtpopeye_objdma: RTL and testbench
==================================

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

Interface
REQ-001 SHALL have parameter LEN, default 10'd768: number of bytes copied per transfer (1..1023).
REQ-002 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-003 SHALL have port clk  input  1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port cpu_cen  input  1: CPU clock enable; asserted at most every second clk.
REQ-005 SHALL have port VB  input  1: vertical blank, clk-synchronous.
REQ-006 SHALL have port busrq_n  output  1: bus request to the main Z80, active low.
REQ-007 SHALL have port busak_n  input  1: bus acknowledge from the Z80, active low.
REQ-008 SHALL have port dma_cs  output  1: steers main RAM addressing to AD_DMA.
REQ-009 SHALL have port AD_DMA  output  10: main RAM byte index.
REQ-010 SHALL have port DD_DMA  input  8: main RAM read data.
REQ-011 SHALL have port obj_addr  output  10, obj_data  output  8, obj_we  output  1: object buffer write port.
REQ-012 SHALL have port obj_bank  output  1: object buffer bank currently being written.
REQ-013 SHALL have port INITEO  output  1: high while a transfer is in progress.
REQ-014 SHALL have port dma_done  output  1: one-clk pulse on successful completion.

Function
REQ-015 SHALL implement states IDLE, REQ, XFER, DRAIN; all transitions qualified by cpu_cen except reset.
REQ-016 SHALL detect a VB rising edge (VB high, previous-cen VB low) in IDLE and go to REQ, driving busrq_n low.
REQ-017 SHALL ignore VB rising edges in any state other than IDLE.
REQ-018 SHALL wait in REQ indefinitely until busak_n is sampled low on a cen; then enter XFER with counter 0; no timeout.
REQ-019 SHALL in XFER, on each cen, drive AD_DMA = counter, keep dma_cs high, increment counter; leave for DRAIN after issuing LEN-1.
REQ-020 SHALL treat read latency as exactly 2 cens: data for the address issued at cen k is sampled from DD_DMA at cen k+2.
REQ-021 SHALL on each sampling cen pulse obj_we for one clk with obj_addr = issued index and obj_data = sampled DD_DMA.
REQ-022 SHALL stay in DRAIN for 2 cens, writing the last two bytes, then release busrq_n and dma_cs, pulse dma_done, enter IDLE.
REQ-023 SHALL produce exactly LEN obj_we pulses per transfer, addresses 0..LEN-1 ascending, no gaps, no repeats.
REQ-024 SHALL abort if busak_n is sampled high in XFER or DRAIN: no further obj_we, busrq_n and dma_cs released next cen, go to IDLE, no dma_done, obj_bank unchanged.
REQ-025 SHALL hold INITEO high from REQ entry until the IDLE return, including abort.
REQ-026 SHALL keep the 10-bit counter from wrapping; LEN bounds it.

Reset
REQ-027 SHALL on rst_n low, asynchronously: state IDLE, busrq_n=1, dma_cs=0, AD_DMA=0, obj_we=0, obj_addr=0, obj_data=0, obj_bank=0, INITEO=0, dma_done=0, VB history=0.
REQ-028 SHALL, when reset is asserted mid-transfer, drop the bus request immediately; the next transfer starts only on a fresh VB rise.

Configuration
REQ-029 SHALL with JTPOPEYE_OBJDMA_DBLBUF_EN defined toggle obj_bank on the clk of each dma_done pulse (double-buffered object RAM).
REQ-030 SHALL without JTPOPEYE_OBJDMA_DBLBUF_EN tie obj_bank to 0 permanently.

Verification
REQ-031 Normal: cen every 2nd clk, RAM model 2-cen latency holding byte = index[7:0] ^ 8'h5A, VB rise, busak_n low 3 cens after busrq_n -> 768 writes, obj_addr 0..767, obj_data match, one dma_done.
REQ-032 Grant delay: busak_n held high 200 cens -> no obj_we and dma_cs low throughout; transfer completes normally after grant.
REQ-033 Abort: busak_n raised after write 100 -> at most 2 further cens of bus, no write past index 101, no dma_done, bank unchanged.
REQ-034 Re-trigger: second VB rise mid-XFER -> ignored, exactly 768 writes; next VB rise after IDLE starts a new transfer.
REQ-035 Reset mid-DRAIN -> all outputs at reset values in the same clk, busrq_n=1.
REQ-036 DBLBUF: three completed transfers -> obj_bank 0->1->0->1 with macro; constant 0 without.

Source files
------------

// File: rtl/jtpopeye_objdma.sv
// Object DMA: on a VB rise, borrows the Z80 bus and copies LEN bytes of main RAM into the object buffer.
// Optional JTPOPEYE_OBJDMA_DBLBUF_EN toggles obj_bank after each completed transfer.
module jtpopeye_objdma #(
  parameter logic [9:0] LEN = 10'd768
) (
  input  logic       rst_n,
  input  logic       clk,
  input  logic       cpu_cen,
  input  logic       VB,
  output logic       busrq_n,
  input  logic       busak_n,
  output logic       dma_cs,
  output logic [9:0] AD_DMA,
  input  logic [7:0] DD_DMA,
  output logic [9:0] obj_addr,
  output logic [7:0] obj_data,
  output logic       obj_we,
  output logic       obj_bank,
  output logic       INITEO,
  output logic       dma_done
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

  state_t     state_q, state_d;
  logic       vb_q, vb_d;
  logic [9:0] cnt_q, cnt_d;
  logic       drain_q, drain_d;
  logic [9:0] ad_q, ad_d;
  logic       vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [9:0] addr_p0_q, addr_p0_d, addr_p1_q, addr_p1_d;
  logic       we_q, we_d;
  logic [9:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vb_q     <= 1'b0;
      cnt_q    <= 10'd0;
      drain_q  <= 1'b0;
      ad_q     <= 10'd0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 10'd0;
      wdata_q  <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vb_q     <= vb_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      ad_q     <= ad_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  // Issued-address pipeline; only the valid bits need a reset
  always_ff @(posedge clk) begin
    addr_p0_q <= addr_p0_d;
    addr_p1_q <= addr_p1_d;
  end

  always_comb begin
    state_d = state_q;
    if (cpu_cen) begin
      case (state_q)
        IDLE:    if (VB && !vb_q) state_d = REQ;
        REQ:     if (!busak_n) state_d = XFER;
        XFER:    if (busak_n) state_d = IDLE;
                 else if (cnt_q == LEN - 10'd1) state_d = DRAIN;
        DRAIN:   if (busak_n || drain_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vb_d      = vb_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    ad_d      = ad_q;
    vld_p0_d  = vld_p0_q;
    vld_p1_d  = vld_p1_q;
    addr_p0_d = addr_p0_q;
    addr_p1_d = addr_p1_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    if (cpu_cen) begin
      vb_d = VB;
      if ((state_q == XFER || state_q == DRAIN) && !busak_n) begin
        // Data for an address issued two cens ago is on DD_DMA now
        vld_p1_d  = vld_p0_q;
        addr_p1_d = addr_p0_q;
        if (vld_p1_q) begin
          we_d    = 1'b1;
          waddr_d = addr_p1_q;
          wdata_d = DD_DMA;
        end
        if (state_q == XFER) begin
          ad_d      = cnt_q;
          vld_p0_d  = 1'b1;
          addr_p0_d = cnt_q;
          if (cnt_q != LEN - 10'd1) cnt_d = cnt_q + 10'd1;
        end else begin
          vld_p0_d = 1'b0;
          drain_d  = 1'b1;
          done_d   = drain_q;
        end
      end else begin
        cnt_d    = 10'd0;
        drain_d  = 1'b0;
        vld_p0_d = 1'b0;
        vld_p1_d = 1'b0;
      end
    end
  end

  always_comb begin
    busrq_n = (state_q == IDLE);
    dma_cs  = (state_q == XFER) || (state_q == DRAIN);
    INITEO  = (state_q != IDLE);
  end

  assign AD_DMA   = ad_q;
  assign obj_we   = we_q;
  assign obj_addr = waddr_q;
  assign obj_data = wdata_q;
  assign dma_done = done_q;

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
  logic bank_q, bank_d;

  always_comb begin
    bank_d = bank_q ^ done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= 1'b0;
    else        bank_q <= bank_d;
  end

  assign obj_bank = bank_q;
`else
  assign obj_bank = 1'b0;
`endif

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Directed bench for jtpopeye_objdma: normal copy, grant delay, abort, re-trigger, reset in DRAIN, bank toggling.
module tb_jtpopeye_objdma;

  logic       rst_n;
  logic       clk = 1'b0;
  logic       cpu_cen = 1'b0;
  logic       VB;
  logic       busrq_n;
  logic       busak_n;
  logic       dma_cs;
  logic [9:0] AD_DMA;
  logic [7:0] DD_DMA = 8'd0;
  logic [9:0] obj_addr;
  logic [7:0] obj_data;
  logic       obj_we;
  logic       obj_bank;
  logic       INITEO;
  logic       dma_done;

  int vectors = 0;
  int errors  = 0;
  int wr_cnt, done_cnt;
  int exp_addr, max_addr;
  logic exp_bank;

  jtpopeye_objdma #(.LEN(10'd768)) dut (
    .rst_n    (rst_n),
    .clk      (clk),
    .cpu_cen  (cpu_cen),
    .VB       (VB),
    .busrq_n  (busrq_n),
    .busak_n  (busak_n),
    .dma_cs   (dma_cs),
    .AD_DMA   (AD_DMA),
    .DD_DMA   (DD_DMA),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_we   (obj_we),
    .obj_bank (obj_bank),
    .INITEO   (INITEO),
    .dma_done (dma_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cpu_cen <= ~cpu_cen;

  function automatic logic [7:0] ram_byte(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Main RAM: registered address plus one cen of read delay gives the 2-cen latency
  always @(posedge clk) if (cpu_cen) DD_DMA <= ram_byte(AD_DMA);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && obj_we === 1'b1) begin
      check("wr_addr", 32'(obj_addr), 32'(exp_addr));
      check("wr_data", 32'(obj_data), 32'(ram_byte(obj_addr)));
      exp_addr++;
      wr_cnt++;
      if (int'(obj_addr) > max_addr) max_addr = int'(obj_addr);
    end
    if (rst_n === 1'b1 && dma_done === 1'b1) done_cnt++;
  end

  task automatic cen_tick();
    do @(negedge clk); while (!cpu_cen);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busrq_n"},  32'(busrq_n),  1);
    check({pfx, "_dma_cs"},   32'(dma_cs),   0);
    check({pfx, "_AD_DMA"},   32'(AD_DMA),   0);
    check({pfx, "_obj_we"},   32'(obj_we),   0);
    check({pfx, "_obj_addr"}, 32'(obj_addr), 0);
    check({pfx, "_obj_data"}, 32'(obj_data), 0);
    check({pfx, "_obj_bank"}, 32'(obj_bank), 0);
    check({pfx, "_INITEO"},   32'(INITEO),   0);
    check({pfx, "_dma_done"}, 32'(dma_done), 0);
  endtask

  // Raise VB, wait for the bus request, hold off the grant gdelay cens, then grant
  task automatic start_xfer(input int gdelay);
    int n;
    int cs_seen;
    VB = 1'b0;
    cen_tick();
    cen_tick();
    wr_cnt = 0; done_cnt = 0; exp_addr = 0; max_addr = 0;
    VB = 1'b1;
    n = 0;
    while (busrq_n && n < 10) begin cen_tick(); n++; end
    check("busrq_asserted", 32'(busrq_n), 0);
    check("initeo_in_req",  32'(INITEO),  1);
    cs_seen = 0;
    for (int i = 0; i < gdelay; i++) begin
      cen_tick();
      if (dma_cs !== 1'b0) cs_seen++;
    end
    check("no_cs_before_grant", 32'(cs_seen), 0);
    check("no_wr_before_grant", 32'(wr_cnt), 0);
    busak_n = 1'b0;
  endtask

  task automatic finish_xfer();
    int n;
    n = 0;
    while (INITEO && n < 4000) begin cen_tick(); n++; end
    check("xfer_ended", 32'(INITEO), 0);
    busak_n = 1'b1;
    cen_tick();
  endtask

  task automatic check_complete(input string pfx);
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    exp_bank = ~exp_bank;
`endif
    check({pfx, "_writes"},   32'(wr_cnt),   768);
    check({pfx, "_max_addr"}, 32'(max_addr), 767);
    check({pfx, "_done"},     32'(done_cnt), 1);
    check({pfx, "_bank"},     32'(obj_bank), 32'(exp_bank));
    check({pfx, "_busrq_n"},  32'(busrq_n),  1);
    check({pfx, "_dma_cs"},   32'(dma_cs),   0);
  endtask

  initial begin
    int n;
    int bus_cens;
    int idle_bad;
    rst_n = 1'b0; VB = 1'b0; busak_n = 1'b1; exp_bank = 1'b0;
    wr_cnt = 0; done_cnt = 0; exp_addr = 0; max_addr = 0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (4) cen_tick();

    // Normal transfer, grant 3 cens after the request
    start_xfer(3);
    finish_xfer();
    check_complete("normal");

    // Grant withheld for 200 cens
    start_xfer(200);
    finish_xfer();
    check_complete("grant_delay");

    // Abort: bus taken back right after the write of index 100
    start_xfer(3);
    n = 0;
    while (!(obj_we && obj_addr == 10'd100) && n < 2000) begin @(posedge clk); #1; n++; end
    check("abort_reached_100", 32'(obj_addr), 100);
    busak_n = 1'b1;
    bus_cens = 0;
    for (int i = 0; i < 6; i++) begin
      cen_tick();
      if (dma_cs) bus_cens++;
    end
    check("abort_bus_cens_le2", 32'(bus_cens <= 2), 1);
    check("abort_max_le101",    32'(max_addr <= 101), 1);
    check("abort_no_done",      32'(done_cnt), 0);
    check("abort_bank",         32'(obj_bank), 32'(exp_bank));
    check("abort_initeo",       32'(INITEO), 0);
    check("abort_busrq_n",      32'(busrq_n), 1);

    // Second VB rise in the middle of XFER is ignored
    start_xfer(3);
    n = 0;
    while (wr_cnt < 300 && n < 2000) begin @(posedge clk); #1; n++; end
    VB = 1'b0;
    cen_tick(); cen_tick();
    VB = 1'b1;
    cen_tick(); cen_tick();
    finish_xfer();
    check_complete("retrigger");
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      cen_tick();
      if (INITEO || !busrq_n) idle_bad++;
    end
    check("retrigger_stays_idle", 32'(idle_bad), 0);
    start_xfer(3);
    finish_xfer();
    check_complete("after_retrigger");

    // Reset asserted during DRAIN
    start_xfer(3);
    n = 0;
    while (!(obj_we && obj_addr == 10'd766) && n < 5000) begin @(posedge clk); #1; n++; end
    check("drain_reached", 32'(obj_addr), 766);
    check("drain_initeo",  32'(INITEO), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    exp_bank = 1'b0;
    VB = 1'b0;
    busak_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      cen_tick();
      if (INITEO || !busrq_n) idle_bad++;
    end
    check("post_reset_idle", 32'(idle_bad), 0);
    start_xfer(3);
    finish_xfer();
    check_complete("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
